// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg: shared types and constants for data_mem_responder.
// Rev 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] ERR_READ_VALUE = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// dmem_array: word storage, synchronous write, combinational read, reset clear.
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder: single-request memory responder with fixed LATENCY.
// Optional error reporting on the MemErr port when DMEM_ERR_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Address,
  input  logic [WORD_W-1:0] Write_data,
  output logic [WORD_W-1:0] Read_data,
  output logic              Ready,
  output logic              Busy
`ifdef DMEM_ERR_EN
  ,
  output logic              MemErr
`endif
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

  dmem_state_e       r_state;
  dmem_state_e       w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_rdata;
  logic [WORD_W-1:0] w_arr_rdata;
  logic [WORD_W-1:0] w_resp_rdata;
  logic              w_accept;
  logic              w_we;
  logic              w_resp_read;

  assign w_accept    = (r_state == IDLE) && (MemRead || MemWrite);
  assign w_resp_read = (r_state == RESP) && !r_write;

`ifdef DMEM_ERR_EN
  logic r_err;

  // Misaligned or beyond the array: flagged at capture, reported in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= (|Address[1:0]) || (|Address[31:IDX_W+2]);
    end
  end

  assign MemErr       = (r_state == RESP) && r_err;
  assign w_we         = (r_state == RESP) && r_write && !r_err;
  assign w_resp_rdata = r_err ? ERR_READ_VALUE : w_arr_rdata;
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{Address[31:IDX_W+2], Address[1:0]};

  assign w_we         = (r_state == RESP) && r_write;
  assign w_resp_rdata = w_arr_rdata;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // Counter is about to reach zero on this edge.
        if (r_cnt <= 4'd1) begin
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_write <= MemWrite;
        r_idx   <= Address[IDX_W+1:2];
        r_wdata <= Write_data;
        r_cnt   <= c_LAT_M1;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_resp_read) begin
        r_rdata <= w_resp_rdata;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_we),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_arr_rdata)
  );

  // The live array word is presented in RESP; the registered copy holds it after.
  assign Read_data = w_resp_read ? w_resp_rdata : r_rdata;
  assign Ready     = (r_state == RESP);
  assign Busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// tb_data_mem_responder: scoreboard bench for data_mem_responder.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        Ready;
  logic        Busy;
`ifdef DMEM_ERR_EN
  logic        MemErr;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_mem [256];
  logic [31:0] last_rd;
  logic [31:0] rd_q [$];

  data_mem_responder #(
    .DEPTH   (256),
    .LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .Ready      (Ready),
    .Busy       (Busy)
`ifdef DMEM_ERR_EN
    ,
    .MemErr     (MemErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic model_err(input logic [31:0] addr);
`ifdef DMEM_ERR_EN
    return (addr[1:0] != 2'b00) || (addr > 32'd1023);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
    last_rd = 32'h0;
    rd_q.delete();
  endtask

  // Issue one request, hold it until Ready, and score latency and data.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data);
    logic [31:0] exp;
    logic        exp_err;
    logic        seen;
    int          k;
    exp_err = model_err(addr);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Address = addr; Write_data = data;
    if (wr) begin
      if (!exp_err) m_mem[addr[9:2]] = data;
    end else begin
      rd_q.push_back(exp_err ? 32'hDEADBEEF : m_mem[addr[9:2]]);
    end
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 16) begin
      @(negedge clk);
      k++;
      n_checks++;
      if (Ready === 1'b1) begin
        seen = 1'b1;
        if (k != LAT) begin
          n_errors++;
          $display("FAIL latency addr=%h: got %0d cycles expected %0d", addr, k, LAT);
        end
        if (!wr) begin
          if (rd_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard: Ready for read with empty queue");
          end else begin
            exp = rd_q.pop_front();
            last_rd = exp;
            n_checks++;
            if (Read_data !== exp) begin
              n_errors++;
              $display("FAIL read_data addr=%h: got %h expected %h", addr, Read_data, exp);
            end
          end
        end else begin
          n_checks++;
          if (Read_data !== last_rd) begin
            n_errors++;
            $display("FAIL read_hold addr=%h: got %h expected %h", addr, Read_data, last_rd);
          end
        end
`ifdef DMEM_ERR_EN
        n_checks++;
        if (MemErr !== exp_err) begin
          n_errors++;
          $display("FAIL memerr addr=%h: got %b expected %b", addr, MemErr, exp_err);
        end
`endif
        MemRead = 1'b0; MemWrite = 1'b0;
      end else if (Busy !== 1'b1) begin
        n_errors++;
        $display("FAIL busy_wait addr=%h: got %b expected 1", addr, Busy);
      end
    end
    if (!seen) begin
      n_errors++;
      $display("FAIL ready_timeout addr=%h: got no Ready expected Ready", addr);
      MemRead = 1'b0; MemWrite = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (Ready !== 1'b0 || Busy !== 1'b0) begin
      n_errors++;
      $display("FAIL after_resp: got Ready=%b Busy=%b expected 0 0", Ready, Busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    n_checks++;
    if (Ready !== 1'b0 || Busy !== 1'b0 || Read_data !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got R=%b B=%b D=%h expected 0 0 0", Ready, Busy, Read_data);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    do_req(1'b1, 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_write_read();
    do_req(1'b0, 1'b1, 32'h40, 32'hCAFEF00D);
    do_req(1'b1, 1'b0, 32'h40, 32'h0);
  endtask

  task automatic test_rw_both();
    do_req(1'b1, 1'b1, 32'h8, 32'h11111111);
    do_req(1'b1, 1'b0, 32'h8, 32'h0);
  endtask

  task automatic test_ignore_during_wait();
    int pulses;
    int k;
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; Address = 32'h40; Write_data = 32'h0;
    rd_q.push_back(m_mem[8'h10]);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b1; Address = 32'h44; Write_data = 32'h12345678;
    pulses = 0;
    for (k = 0; k < 8; k++) begin
      if (Ready === 1'b1) begin
        pulses++;
        if (rd_q.size() != 0) begin
          last_rd = rd_q.pop_front();
          n_checks++;
          if (Read_data !== last_rd) begin
            n_errors++;
            $display("FAIL ignore_rdata: got %h expected %h", Read_data, last_rd);
          end
        end
        MemWrite = 1'b0;
      end
      @(negedge clk);
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    n_checks++;
    if (pulses != 1) begin
      n_errors++;
      $display("FAIL ignore_pulses: got %0d expected 1", pulses);
    end
    do_req(1'b1, 1'b0, 32'h44, 32'h0);
  endtask

  task automatic test_wrap();
    do_req(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
    do_req(1'b1, 1'b0, 32'h0, 32'h0);
    do_req(1'b1, 1'b0, 32'h402, 32'h0);
    do_req(1'b0, 1'b1, 32'h7, 32'h0BADF00D);
    do_req(1'b1, 1'b0, 32'h4, 32'h0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b1; Address = 32'h20; Write_data = 32'h77777777;
    @(negedge clk);
    n_checks++;
    if (Busy !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_busy: got %b expected 1", Busy);
    end
    reset = 1'b0;
    MemWrite = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (Ready !== 1'b0 || Busy !== 1'b0 || Read_data !== 32'h0) begin
      n_errors++;
      $display("FAIL mid_reset: got R=%b B=%b D=%h expected 0 0 0", Ready, Busy, Read_data);
    end
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (Ready !== 1'b0) begin
        n_errors++;
        $display("FAIL mid_ready: got %b expected 0", Ready);
      end
    end
    @(posedge clk);
    #2 reset = 1'b1;
    do_req(1'b1, 1'b0, 32'h20, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic        rd;
    logic [31:0] a;
    for (int i = 0; i < 24; i++) begin
      rd = 1'($urandom_range(0, 1));
      a  = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
      do_req(rd, ~rd, a, $urandom);
    end
  endtask

  initial begin
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Address = 32'h0; Write_data = 32'h0;
    test_reset();
    test_write_read();
    test_rw_both();
    test_ignore_during_wait();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (rd_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- DEPTH, 256, number of 32-bit words stored; power of two, 2 to 65536.
- LATENCY, 2, cycles from request acceptance to Ready; range 1 to 15.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning (clock and reset first):
- clk, in, 1, single clock; rising edge.
- reset, in, 1, asynchronous, active-low reset.
- MemRead, in, 1, read request.
- MemWrite, in, 1, write request.
- Address, in, 32, byte address; word index is Address[log2(DEPTH)+1:2].
- Write_data, in, 32, write data.
- Read_data, out, 32, read data; valid in the Ready cycle.
- Ready, out, 1, one-cycle completion pulse.
- Busy, out, 1, high while a request is in flight.
- MemErr, out, 1, error flag for the completed request (only with DMEM_ERR_EN).

Function
REQ-003 The block SHALL use a three-state FSM with states IDLE, WAIT and RESP.
REQ-004 In IDLE with MemRead|MemWrite high, the block SHALL accept the request: capture Address, Write_data and the op, load the wait counter with LATENCY-1, and go to WAIT (or to RESP if LATENCY=1).
REQ-005 If MemRead and MemWrite are both high at acceptance, the block SHALL treat the request as a write.
REQ-006 In WAIT the block SHALL decrement the counter each cycle and go to RESP when it reaches 0.
REQ-007 RESP SHALL last exactly one cycle with Ready=1 and SHALL then return to IDLE, so Ready rises exactly LATENCY cycles after the acceptance edge.
REQ-008 Writes SHALL update the array at the RESP clock edge.
REQ-009 Reads SHALL drive the array word onto Read_data in RESP.
REQ-010 Outside RESP, Read_data SHALL hold its last value.
REQ-011 Request inputs SHALL be ignored in WAIT and RESP; the earliest next acceptance is the cycle after RESP.
REQ-012 The initiator SHALL hold its request stable until Ready; only the captured copy is used.
REQ-013 Busy SHALL equal (state != IDLE).
REQ-014 Address bits above the index SHALL be ignored, so out-of-range addresses wrap modulo DEPTH.
REQ-015 Address[1:0] SHALL be ignored; all accesses are word-aligned.
REQ-016 A read of a never-written word SHALL return 32'h0, because the array is cleared by reset.

Reset
REQ-017 Asserting reset low SHALL force the FSM to IDLE, the counter to 0, Ready=0, Busy=0, Read_data=32'h0 and MemErr=0, and SHALL clear every array word to 0.
REQ-018 Reset asserted mid-request SHALL abort the request, so no write is committed and no Ready is issued.
REQ-019 The first acceptance SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-020 With macro DMEM_ERR_EN defined:
- MemErr SHALL pulse with Ready when the captured Address[1:0]!=0 or the address exceeds (DEPTH*4-1).
- An erroring write SHALL NOT modify the array.
- An erroring read SHALL return 32'hDEADBEEF.
REQ-021 Without DMEM_ERR_EN, the MemErr port and its logic SHALL be absent, and REQ-014/REQ-015 SHALL apply unchanged.

Structure
REQ-022 Package dmem_pkg SHALL hold:
- the FSM state enum (IDLE, WAIT, RESP);
- the constant ERR_READ_VALUE=32'hDEADBEEF;
- the word-width constant 32.
REQ-023 The storage array SHALL be one sub-module, dmem_array (synchronous write, combinational read, clear on reset); the FSM stays in data_mem_responder.

Verification
REQ-024 Reset low for 3 cycles, then release -> all outputs are 0, and a read of 0x10 returns 0x00000000 with Ready on cycle 2 after acceptance.
REQ-025 Write 0xCAFEF00D to 0x40, then read 0x40 -> Ready pulses once per request, 2 cycles after each acceptance, and the read returns 0xCAFEF00D.
REQ-026 Read and write asserted together to 0x8 with data 0x11111111, then a read of 0x8 -> 0x11111111.
REQ-027 A second request driven during WAIT -> ignored; Ready pulses only once for the first request.
REQ-028 Write to 0x400 (DEPTH=256) -> without DMEM_ERR_EN, word 0 = data; with DMEM_ERR_EN, MemErr=1, the array is unchanged, and a read of 0x402 returns 0xDEADBEEF.
REQ-029 Reset asserted during WAIT of a write to 0x20 -> no Ready, and a subsequent read of 0x20 returns 0.
